// File: rtl/led_pkg.sv
// Shared constants and types for the LED pattern sequencer.
package led_pkg;

    localparam logic [1:0] MODE_ROT_L    = 2'd0;
    localparam logic [1:0] MODE_ROT_R    = 2'd1;
    localparam logic [1:0] MODE_PINGPONG = 2'd2;
    localparam logic [1:0] MODE_SHIFT_IN = 2'd3;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

endpackage

// File: rtl/tick_gen.sv
// Step prescaler: free-running count while enabled, STEP flags the terminal count.
module tick_gen #(
    parameter int PRESC_BITS = 19
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic EN,
    input  logic CLR,
    output logic STEP
);

    localparam logic [PRESC_BITS-1:0] COUNT_MAX = {PRESC_BITS{1'b1}};

    logic [PRESC_BITS-1:0] count_r;

    // Prescaler counter; wraps naturally from COUNT_MAX to zero.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            count_r <= {PRESC_BITS{1'b0}};
        end else if (CLR) begin
            count_r <= {PRESC_BITS{1'b0}};
        end else if (EN) begin
            count_r <= count_r + PRESC_BITS'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign STEP = EN & (count_r == COUNT_MAX);

endmodule

// File: rtl/led_shifter_n.sv
// LED pattern sequencer: rotate, ping-pong and serial shift modes with a prescaled step.
module led_shifter_n
    import led_pkg::*;
#(
    parameter int                 WIDTH      = 8,
    parameter int                 PRESC_BITS = 19,
    parameter logic [WIDTH-1:0]   INIT       = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DIN,
    input  logic             SIN,
    output logic [WIDTH-1:0] LEDS,
    output logic             TICK
);

    logic             step_raw_s;
    logic             step_s;
    logic [WIDTH-1:0] pattern_r;
    logic [WIDTH-1:0] next_pattern_s;
    logic [WIDTH-1:0] rot_l_s;
    logic [WIDTH-1:0] rot_r_s;
    dir_t             dir_r;
    dir_t             next_dir_s;
    logic             tick_r;

    tick_gen #(
        .PRESC_BITS (PRESC_BITS)
    ) u_tick_gen (
        .CLK  (CLK),
        .RSTN (RSTN),
        .EN   (EN),
        .CLR  (LOAD),
        .STEP (step_raw_s)
    );

    // A load on the terminal-count edge wins over the step.
    assign step_s = step_raw_s & ~LOAD;

    // Next pattern and bounce direction for the current mode.
    always_comb begin
        rot_l_s        = {pattern_r[WIDTH-2:0], pattern_r[WIDTH-1]};
        rot_r_s        = {pattern_r[0], pattern_r[WIDTH-1:1]};
        next_pattern_s = pattern_r;
        next_dir_s     = DIR_LEFT;
        case (MODE)
            MODE_ROT_L: begin
                next_pattern_s = rot_l_s;
            end
            MODE_ROT_R: begin
                next_pattern_s = rot_r_s;
            end
            MODE_PINGPONG: begin
                // Only the leading-edge bit for the current direction turns the bounce.
                if (dir_r == DIR_LEFT) begin
                    if (pattern_r[WIDTH-1]) begin
                        next_pattern_s = rot_r_s;
                        next_dir_s     = DIR_RIGHT;
                    end else begin
                        next_pattern_s = rot_l_s;
                        next_dir_s     = DIR_LEFT;
                    end
                end else begin
                    if (pattern_r[0]) begin
                        next_pattern_s = rot_l_s;
                        next_dir_s     = DIR_LEFT;
                    end else begin
                        next_pattern_s = rot_r_s;
                        next_dir_s     = DIR_RIGHT;
                    end
                end
            end
            MODE_SHIFT_IN: begin
                next_pattern_s = {pattern_r[WIDTH-2:0], SIN};
            end
            default: begin
                next_pattern_s = pattern_r;
            end
        endcase
    end

    // Pattern register: load has priority, otherwise advance on a step.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pattern_r <= INIT;
        end else if (LOAD) begin
            pattern_r <= DIN;
        end else if (step_s) begin
            pattern_r <= next_pattern_s;
        end else begin
            pattern_r <= pattern_r;
        end
    end

    // Bounce direction; outside ping-pong it is parked at LEFT so entry starts leftward.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            dir_r <= DIR_LEFT;
        end else if (LOAD || (MODE != MODE_PINGPONG)) begin
            dir_r <= DIR_LEFT;
        end else if (step_s) begin
            dir_r <= next_dir_s;
        end else begin
            dir_r <= dir_r;
        end
    end

    // TICK marks the single cycle showing a freshly stepped pattern.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            tick_r <= 1'b0;
        end else begin
            tick_r <= step_s;
        end
    end

    assign LEDS = pattern_r;
    assign TICK = tick_r;

endmodule

// File: doc/led_shifter_n.md
# led_shifter_n

Parametrised LED pattern sequencer for N outputs with a built-in step prescaler. It supports rotate-left, rotate-right, ping-pong bounce and serial shift-in modes, plus synchronous pattern load and a step-enable. It drives a board LED bank directly from the system clock and exports a one-cycle step pulse for chaining or debug.

## Interface
- WIDTH, 8: number of LED outputs; must be ≥ 2.
- PRESC_BITS, 19: prescaler width; one step every 2^PRESC_BITS enabled clocks; must be ≥ 1.
- INIT, {{(WIDTH-1){1'b0}},1'b1}: pattern loaded on reset.
- CLK  in  1  system clock; all state changes on its rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- EN  in  1  step enable; when low, the prescaler and the pattern hold.
- MODE  in  2  0 = rotate left, 1 = rotate right, 2 = ping-pong, 3 = shift left with serial in.
- LOAD  in  1  synchronous pattern load, one-cycle strobe.
- DIN  in  WIDTH  pattern captured when LOAD = 1.
- SIN  in  1  serial bit shifted into bit 0 in mode 3.
- LEDS  out  WIDTH  current pattern, registered; LEDS[0] is the LSB.
- TICK  out  1  registered pulse, high for the one cycle in which LEDS shows a freshly stepped value.

## Operation
- Reset (RSTN = 0, asynchronous) sets:
  - pattern to INIT;
  - prescaler count to 0;
  - dir to LEFT;
  - TICK to 0.
- Step condition: EN = 1, count = 2^PRESC_BITS−1 and LOAD = 0. On a step:
  - count wraps to 0;
  - the pattern updates per MODE;
  - TICK ← 1.
- When EN = 1 without a step, count increments and TICK ← 0.
- When EN = 0, count and pattern hold and TICK ← 0.
- Mode 0: pattern ← {p[W−2:0], p[W−1]}.
- Mode 1: pattern ← {p[0], p[W−1:1]}.
- Mode 2 uses a dir state machine with states LEFT and RIGHT:
  - In LEFT with p[W−1] = 1: dir ← RIGHT and this step rotates right.
  - In LEFT otherwise: rotate left.
  - In RIGHT with p[0] = 1: dir ← LEFT and this step rotates left.
  - In RIGHT otherwise: rotate right.
  - Only the leading-edge bit for the current direction is checked.
  - A single-bit pattern gives period 2·(WIDTH−1) steps.
  - All-ones stays all-ones while dir alternates each step.
- Mode 3: pattern ← {p[W−2:0], SIN}; SIN is sampled on the step edge.
- dir is forced to LEFT on every clock where MODE ≠ 2, so entering ping-pong always starts leftward.
- A MODE change takes effect at the next step; no other state is disturbed.
- LOAD = 1 has priority over the step, regardless of EN. It sets:
  - pattern ← DIN;
  - count ← 0;
  - dir ← LEFT;
  - TICK ← 0.
- An all-zero pattern stays zero in modes 0–2; no error or flag is raised.

## Timing
- LEDS and TICK are direct register outputs; there is no combinational path from inputs to outputs.
- Reset is asynchronous: LEDS = INIT and TICK = 0 while RSTN = 0.
- After RSTN deasserts with EN held high, the first step lands on rising edge 2^PRESC_BITS.
- Steps then repeat every 2^PRESC_BITS cycles.
- TICK is high exactly one cycle per step; with PRESC_BITS = 1 it is high every other cycle.
- LOAD: DIN appears on LEDS one cycle after the LOAD edge.
- After LOAD, the next step is 2^PRESC_BITS enabled cycles later.
- An EN low period pauses the step timeline without discarding elapsed counts.
- RSTN asserted mid-period discards the partial count.

## Structure
- Shared package led_pkg holds:
  - MODE_ROT_L = 2'd0;
  - MODE_ROT_R = 2'd1;
  - MODE_PINGPONG = 2'd2;
  - MODE_SHIFT_IN = 2'd3;
  - dir type with DIR_LEFT / DIR_RIGHT.
- Sub-module tick_gen (params PRESC_BITS):
  - inputs CLK, RSTN, EN, CLR;
  - output STEP, a combinational terminal-count qualified by EN.
- led_shifter_n itself holds the pattern register, the dir FSM and the TICK register.

## Test plan
All scenarios use WIDTH = 8, PRESC_BITS = 2 (one step per 4 cycles) and INIT = 8'h01.
- Reset, EN = 1, MODE = 0 → LEDS 01 → 02 at edge 4 → 04 at edge 8 … → 80 at edge 28 → 01 at edge 32; TICK high exactly at edges 4, 8, 12 ….
- MODE = 1 from 01 → 80, 40, 20 on successive steps.
- MODE = 2 from 01 → 02, 04 … 80, 40 … 01, 02, with a period of 14 steps. Loading FF in mode 2 → FF persists and TICK still pulses.
- LOAD DIN = 00, then MODE = 3 with SIN = 1 → 01, 03, 07 … FF, FF. Then SIN = 0 → FE, FC.
- LOAD with DIN = A5 on the same edge as a step, MODE = 0 → LEDS = A5 and TICK = 0. Four cycles later LEDS = 4B with TICK = 1.
- EN low for 10 cycles mid-period → LEDS and TICK frozen; the step resumes after the remaining count.
- RSTN pulsed low between clock edges → LEDS = 01 and TICK = 0 immediately, before the next edge.
